// File: rtl/fp64_fma_arbiter_if.sv
// Requester-side bus of fp64_fma_arbiter: request handshake with operands,
// plus the shared response channel returned to the owning requester.
interface fp64_fma_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*64-1:0]    req_a;
    logic [NUM_REQ*64-1:0]    req_b;
    logic [NUM_REQ*64-1:0]    req_c;
    logic [NUM_REQ-1:0]       req_sub;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [63:0]              rsp_data;
    logic [TAG_W-1:0]         rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_c, req_sub, req_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_sub, req_tag,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/fp64_fma_arbiter.sv
// Round-robin front end for a shared fixed-latency fp64 FMA core: grants one
// requester per cycle, tracks in-flight ops and routes results back to owners.
module fp64_fma_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = $clog2(LATENCY + 2)
) (
    input  logic                clk,
    input  logic                rst,
    fp64_fma_arbiter_if.slave   bus,
    input  logic                hold,
    output logic [63:0]         fma_a,
    output logic [63:0]         fma_b,
    output logic [63:0]         fma_c,
    input  logic [63:0]         fma_result,
    output logic                busy,
    output logic [CNT_W-1:0]    inflight
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic               accept;
    logic               retire;
    logic [NUM_REQ-1:0] grant_oh;
    logic [TAG_W-1:0]   acc_tag;
    logic [CNT_W-1:0]   inflight_next;

    logic [LATENCY-1:0] pipe_valid;
    logic [IDX_W-1:0]   pipe_idx [LATENCY];
    logic [TAG_W-1:0]   pipe_tag [LATENCY];

    // Search starts just after the last winner and wraps over all requesters.
    always_comb begin : arbitrate
        logic [IDX_W-1:0] cand;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept        = grant_found && !hold && !rst;
    assign grant_oh      = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.req_ready = grant_oh;
    assign retire        = pipe_valid[LATENCY-1];

    // Subtract is folded into the addend by flipping its sign bit, NaN and zero included.
    always_comb begin : operand_mux
        fma_a   = '0;
        fma_b   = '0;
        fma_c   = '0;
        acc_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                fma_a   = bus.req_a[64*i +: 64];
                fma_b   = bus.req_b[64*i +: 64];
                fma_c   = {bus.req_c[64*i+63] ^ bus.req_sub[i], bus.req_c[64*i +: 63]};
                acc_tag = bus.req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // NOTE: the payload shift register has no reset; it is only read when its valid bit is set.
    always_ff @(posedge clk) begin
        pipe_idx[0] <= grant_idx;
        pipe_tag[0] <= acc_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_idx[i] <= pipe_idx[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_tag   <= '0;
        end else if (retire) begin
            bus.rsp_valid <= NUM_REQ'(1) << pipe_idx[LATENCY-1];
            bus.rsp_data  <= fma_result;
            bus.rsp_tag   <= pipe_tag[LATENCY-1];
        end else begin
            bus.rsp_valid <= '0;
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (accept && !retire) begin
            inflight_next = inflight + CNT_W'(1);
        end else if (!accept && retire) begin
            inflight_next = inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            busy     <= 1'b0;
        end else begin
            inflight <= inflight_next;
            busy     <= (inflight_next != '0);
        end
    end
endmodule
